// File: rtl/riscv_lsu_if.sv
// rtl/riscv_lsu_if.sv - request, data-cache and response bundle of the load/store unit
interface riscv_lsu_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = XLEN / 8;

  logic              stall;
  logic              req_valid;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [4:0]        req_rd;

  logic [ADDR_W-1:0] dcache_addr;
  logic [NB-1:0]     dcache_we;
  logic              dcache_re;
  logic [XLEN-1:0]   dcache_din;
  logic [XLEN-1:0]   dcache_dout;

  logic              resp_valid;
  logic [4:0]        resp_rd;
  logic [XLEN-1:0]   resp_data;
  logic              misalign_exc;
  logic              exc_store;

  modport master (
    output stall, req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
    output dcache_dout,
    input  dcache_addr, dcache_we, dcache_re, dcache_din,
    input  resp_valid, resp_rd, resp_data, misalign_exc, exc_store
  );

  modport slave (
    input  stall, req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
    input  dcache_dout,
    output dcache_addr, dcache_we, dcache_re, dcache_din,
    output resp_valid, resp_rd, resp_data, misalign_exc, exc_store
  );
endinterface

// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - load/store unit: store lane replication, one outstanding load, extension
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them down.
module riscv_lsu #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic       clk,
  input  logic       reset,
  riscv_lsu_if.slave lsu
);
  localparam int NB  = XLEN / 8;
  localparam int OFF = $clog2(NB);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t         state, state_nx;
  logic [4:0]     pend_rd, pend_rd_nx;
  logic [1:0]     pend_size, pend_size_nx;
  logic           pend_uns, pend_uns_nx;
  logic [OFF-1:0] pend_off, pend_off_nx;

  logic [2:0]     f3;
  logic [1:0]     size;
  logic [OFF-1:0] low_mask;
  logic [OFF-1:0] off;
  logic [NB-1:0]  size_mask;
  logic [XLEN-1:0] din;
  logic           misaligned;
  logic           load_acc;
  logic           resp_valid;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] resp_data;
  logic           fill;
  int             nbits;

  // Illegal size codes collapse to a word access, keeping the extension bit.
  always_comb begin
    f3 = lsu.req_funct3;
    if (f3 == 3'b111 || (XLEN == 32 && f3[1:0] == 2'b11) || (XLEN == 32 && f3 == 3'b110))
      f3 = {lsu.req_funct3[2], 2'b10};
  end

  assign size = f3[1:0];

  always_comb begin
    low_mask  = '0;
    size_mask = {NB{1'b1}};
    case (size)
      2'd0: begin low_mask = '0;        size_mask = NB'(1);  end
      2'd1: begin low_mask = OFF'(1);   size_mask = NB'(3);  end
      2'd2: begin low_mask = OFF'(3);   size_mask = NB'(15); end
      default: begin low_mask = OFF'(7); size_mask = {NB{1'b1}}; end
    endcase
  end

  assign off = lsu.req_addr[OFF-1:0] & ~low_mask;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = |(lsu.req_addr[OFF-1:0] & low_mask);
`else
  assign misaligned = 1'b0;
`endif

  // Each lane takes the byte of the access-sized chunk it would hold at that lane.
  always_comb begin
    din = '0;
    for (int i = 0; i < NB; i++) begin
      case (size)
        2'd0:    din[8*i +: 8] = lsu.req_wdata[7:0];
        2'd1:    din[8*i +: 8] = lsu.req_wdata[8*(i%2) +: 8];
        2'd2:    din[8*i +: 8] = lsu.req_wdata[8*(i%4) +: 8];
        default: din[8*i +: 8] = lsu.req_wdata[8*(i%8) +: 8];
      endcase
    end
  end

  assign lsu.dcache_addr = {lsu.req_addr[ADDR_W-1:OFF], OFF'(0)};
  assign lsu.dcache_din  = din;
  assign lsu.dcache_we   = (lsu.req_valid && lsu.req_store && !misaligned) ? (size_mask << off) : '0;
  assign lsu.dcache_re   = lsu.req_valid && !lsu.req_store && !misaligned;

  assign load_acc = lsu.req_valid && !lsu.stall && !lsu.req_store && !misaligned;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      pend_rd   <= '0;
      pend_size <= '0;
      pend_uns  <= 1'b0;
      pend_off  <= '0;
    end else begin
      state     <= state_nx;
      pend_rd   <= pend_rd_nx;
      pend_size <= pend_size_nx;
      pend_uns  <= pend_uns_nx;
      pend_off  <= pend_off_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    pend_rd_nx   = pend_rd;
    pend_size_nx = pend_size;
    pend_uns_nx  = pend_uns;
    pend_off_nx  = pend_off;
    resp_valid   = 1'b0;
    if (!lsu.stall) begin
      if (state == S_WAIT) begin
        resp_valid = 1'b1;
        state_nx   = S_IDLE;
      end
      if (load_acc) begin
        state_nx     = S_WAIT;
        pend_rd_nx   = lsu.req_rd;
        pend_size_nx = size;
        pend_uns_nx  = f3[2];
        pend_off_nx  = off;
      end
    end
  end

  assign shifted = lsu.dcache_dout >> {pend_off, 3'b000};

  always_comb begin
    nbits = XLEN;
    fill  = 1'b0;
    case (pend_size)
      2'd0:    begin nbits = 8;    fill = shifted[7];      end
      2'd1:    begin nbits = 16;   fill = shifted[15];     end
      2'd2:    begin nbits = 32;   fill = shifted[31];     end
      default: begin nbits = XLEN; fill = shifted[XLEN-1]; end
    endcase
    fill      = fill && !pend_uns;
    resp_data = shifted;
    for (int i = 0; i < XLEN; i++)
      if (i >= nbits) resp_data[i] = fill;
  end

  assign lsu.resp_valid = resp_valid;
  assign lsu.resp_rd    = pend_rd;
  assign lsu.resp_data  = resp_data;

`ifdef LSU_MISALIGN_TRAP_EN
  logic exc_q, exc_store_q;

  // Next value depends only on this cycle's acceptance, so a stall never stretches the pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exc_q       <= 1'b0;
      exc_store_q <= 1'b0;
    end else begin
      exc_q       <= lsu.req_valid && !lsu.stall && misaligned;
      exc_store_q <= lsu.req_valid && !lsu.stall && misaligned && lsu.req_store;
    end
  end

  assign lsu.misalign_exc = exc_q;
  assign lsu.exc_store    = exc_store_q;
`else
  assign lsu.misalign_exc = 1'b0;
  assign lsu.exc_store    = 1'b0;
`endif
endmodule

// File: tb/tb_riscv_lsu.sv
// tb/tb_riscv_lsu.sv - directed self-checking bench for riscv_lsu at XLEN 32 and 64
module tb_riscv_lsu;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  riscv_lsu_if #(.XLEN(32), .ADDR_W(32)) i32 ();
  riscv_lsu_if #(.XLEN(64), .ADDR_W(32)) i64 ();

  riscv_lsu #(.XLEN(32), .ADDR_W(32)) u32 (.clk(clk), .reset(reset), .lsu(i32.slave));
  riscv_lsu #(.XLEN(64), .ADDR_W(32)) u64 (.clk(clk), .reset(reset), .lsu(i64.slave));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req32(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd);
    i32.req_valid  = 1'b1;
    i32.req_store  = st;
    i32.req_funct3 = f3;
    i32.req_addr   = a;
    i32.req_wdata  = wd;
    i32.req_rd     = rd;
  endtask

  task automatic req64(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [63:0] wd, input logic [4:0] rd);
    i64.req_valid  = 1'b1;
    i64.req_store  = st;
    i64.req_funct3 = f3;
    i64.req_addr   = a;
    i64.req_wdata  = wd;
    i64.req_rd     = rd;
  endtask

  initial begin
    reset = 1'b1;
    i32.stall = 1'b0; i32.req_valid = 1'b0; i32.req_store = 1'b0; i32.req_funct3 = '0;
    i32.req_addr = '0; i32.req_wdata = '0; i32.req_rd = '0; i32.dcache_dout = '0;
    i64.stall = 1'b0; i64.req_valid = 1'b0; i64.req_store = 1'b0; i64.req_funct3 = '0;
    i64.req_addr = '0; i64.req_wdata = '0; i64.req_rd = '0; i64.dcache_dout = '0;

    tick(); tick();
    #4;
    check_eq("rst_resp_valid", 64'(i32.resp_valid), 64'd0);
    check_eq("rst_misalign", 64'(i32.misalign_exc), 64'd0);
    check_eq("rst_exc_store", 64'(i32.exc_store), 64'd0);
    check_eq("idle_we", 64'(i32.dcache_we), 64'd0);
    check_eq("idle_re", 64'(i32.dcache_re), 64'd0);
    tick();
    reset = 1'b0;

    // SB 0x1003
    tick();
    req32(1'b1, 3'b000, 32'h1003, 32'h0000_00AB, 5'd1);
    #4;
    check_eq("sb_addr", 64'(i32.dcache_addr), 64'h1000);
    check_eq("sb_we", 64'(i32.dcache_we), 64'h8);
    check_eq("sb_din", 64'(i32.dcache_din), 64'hABAB_ABAB);
    check_eq("sb_re", 64'(i32.dcache_re), 64'd0);
    tick();
    i32.req_valid = 1'b0;
    #4;
    check_eq("sb_no_resp", 64'(i32.resp_valid), 64'd0);

    // LH then LHU at 0x2002
    tick();
    req32(1'b0, 3'b001, 32'h2002, 32'h0, 5'd5);
    #4;
    check_eq("lh_re", 64'(i32.dcache_re), 64'd1);
    check_eq("lh_we", 64'(i32.dcache_we), 64'd0);
    tick();
    i32.req_valid = 1'b0;
    i32.dcache_dout = 32'h8001_1234;
    #4;
    check_eq("lh_valid", 64'(i32.resp_valid), 64'd1);
    check_eq("lh_data", 64'(i32.resp_data), 64'hFFFF_8001);
    check_eq("lh_rd", 64'(i32.resp_rd), 64'd5);
    tick();
    req32(1'b0, 3'b101, 32'h2002, 32'h0, 5'd6);
    #4;
    check_eq("lh_once", 64'(i32.resp_valid), 64'd0);
    tick();
    i32.req_valid = 1'b0;
    #4;
    check_eq("lhu_valid", 64'(i32.resp_valid), 64'd1);
    check_eq("lhu_data", 64'(i32.resp_data), 64'h0000_8001);
    check_eq("lhu_rd", 64'(i32.resp_rd), 64'd6);

    // LBU 0x2001 with a three-cycle stall in the response cycle
    tick();
    req32(1'b0, 3'b100, 32'h2001, 32'h0, 5'd7);
    tick();
    i32.req_valid = 1'b0;
    i32.stall = 1'b1;
    i32.dcache_dout = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      #4;
      check_eq($sformatf("lbu_stall%0d", k), 64'(i32.resp_valid), 64'd0);
      if (k < 2) tick();
    end
    tick();
    i32.stall = 1'b0;
    i32.dcache_dout = 32'h8001_1234;
    #4;
    check_eq("lbu_valid", 64'(i32.resp_valid), 64'd1);
    check_eq("lbu_data", 64'(i32.resp_data), 64'h0000_0012);
    check_eq("lbu_rd", 64'(i32.resp_rd), 64'd7);
    tick();
    #4;
    check_eq("lbu_once", 64'(i32.resp_valid), 64'd0);

    // Back-to-back LW 0x3000, 0x3004
    tick();
    req32(1'b0, 3'b010, 32'h3000, 32'h0, 5'd8);
    tick();
    req32(1'b0, 3'b010, 32'h3004, 32'h0, 5'd9);
    i32.dcache_dout = 32'h1111_2222;
    #4;
    check_eq("b2b0_valid", 64'(i32.resp_valid), 64'd1);
    check_eq("b2b0_data", 64'(i32.resp_data), 64'h1111_2222);
    check_eq("b2b0_rd", 64'(i32.resp_rd), 64'd8);
    tick();
    i32.req_valid = 1'b0;
    i32.dcache_dout = 32'h3333_4444;
    #4;
    check_eq("b2b1_valid", 64'(i32.resp_valid), 64'd1);
    check_eq("b2b1_data", 64'(i32.resp_data), 64'h3333_4444);
    check_eq("b2b1_rd", 64'(i32.resp_rd), 64'd9);
    tick();
    #4;
    check_eq("b2b_end", 64'(i32.resp_valid), 64'd0);

    // Misaligned LW 0x1002
    tick();
    req32(1'b0, 3'b010, 32'h1002, 32'h0, 5'd10);
    #4;
`ifdef LSU_MISALIGN_TRAP_EN
    check_eq("mis_re", 64'(i32.dcache_re), 64'd0);
    tick();
    i32.req_valid = 1'b0;
    #4;
    check_eq("mis_exc", 64'(i32.misalign_exc), 64'd1);
    check_eq("mis_exc_store", 64'(i32.exc_store), 64'd0);
    check_eq("mis_no_resp", 64'(i32.resp_valid), 64'd0);
    tick();
    #4;
    check_eq("mis_exc_end", 64'(i32.misalign_exc), 64'd0);
    check_eq("mis_no_resp2", 64'(i32.resp_valid), 64'd0);
    // Misaligned SH with a stall in the exception cycle
    tick();
    req32(1'b1, 3'b001, 32'h1001, 32'h0000_BEEF, 5'd0);
    #4;
    check_eq("mis_sh_we", 64'(i32.dcache_we), 64'd0);
    tick();
    i32.req_valid = 1'b0;
    i32.stall = 1'b1;
    #4;
    check_eq("mis_sh_exc", 64'(i32.misalign_exc), 64'd1);
    check_eq("mis_sh_store", 64'(i32.exc_store), 64'd1);
    tick();
    #4;
    check_eq("mis_sh_pulse", 64'(i32.misalign_exc), 64'd0);
    i32.stall = 1'b0;
`else
    check_eq("mis_addr", 64'(i32.dcache_addr), 64'h1000);
    check_eq("mis_re", 64'(i32.dcache_re), 64'd1);
    tick();
    i32.req_valid = 1'b0;
    i32.dcache_dout = 32'hCAFE_F00D;
    #4;
    check_eq("mis_valid", 64'(i32.resp_valid), 64'd1);
    check_eq("mis_data", 64'(i32.resp_data), 64'hCAFE_F00D);
    check_eq("mis_exc", 64'(i32.misalign_exc), 64'd0);
`endif

    // Reset while a load is in flight
    tick();
    req32(1'b0, 3'b010, 32'h4000, 32'h0, 5'd11);
    tick();
    i32.req_valid = 1'b0;
    reset = 1'b1;
    #4;
    check_eq("rstw_during", 64'(i32.resp_valid), 64'd0);
    tick();
    reset = 1'b0;
    #4;
    check_eq("rstw_after0", 64'(i32.resp_valid), 64'd0);
    tick();
    #4;
    check_eq("rstw_after1", 64'(i32.resp_valid), 64'd0);

    // XLEN=64: SD, SB, LW upper half
    tick();
    req64(1'b1, 3'b011, 32'h10, 64'h0123_4567_89AB_CDEF, 5'd0);
    #4;
    check_eq("sd_we", 64'(i64.dcache_we), 64'hFF);
    check_eq("sd_din", i64.dcache_din, 64'h0123_4567_89AB_CDEF);
    check_eq("sd_addr", 64'(i64.dcache_addr), 64'h10);
    tick();
    req64(1'b1, 3'b000, 32'h13, 64'h0000_0000_0000_00AB, 5'd0);
    #4;
    check_eq("sb64_we", 64'(i64.dcache_we), 64'h08);
    check_eq("sb64_din", i64.dcache_din, 64'hABAB_ABAB_ABAB_ABAB);
    tick();
    req64(1'b0, 3'b010, 32'h14, 64'h0, 5'd3);
    #4;
    check_eq("lw64_addr", 64'(i64.dcache_addr), 64'h10);
    tick();
    i64.req_valid = 1'b0;
    i64.dcache_dout = 64'h8000_0000_1111_1111;
    #4;
    check_eq("lw64_valid", 64'(i64.resp_valid), 64'd1);
    check_eq("lw64_data", i64.resp_data, 64'hFFFF_FFFF_8000_0000);
    check_eq("lw64_rd", 64'(i64.resp_rd), 64'd3);
    tick();
    #4;
    check_eq("lw64_once", 64'(i64.resp_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
